// File: rtl/parking_pkg.sv
// Shared types, widths and defaults for the parking fee unit.
package parking_pkg;

    localparam int FEE_W          = 12;
    localparam int REV_W          = 16;
    localparam int FREE_UNITS_DEF = 4;
    localparam int BASE_FEE_DEF   = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_PRESENT = 2'd2
    } fee_state_e;

    // Units charged at the per-unit rate; clamps at zero instead of wrapping.
    function automatic logic [7:0] billable_units(input logic [7:0] dur,
                                                  input logic [7:0] free_units);
        return (dur > free_units) ? (dur - free_units) : 8'd0;
    endfunction

endpackage

// File: rtl/parking_fee_unit_if.sv
// Exit-event and fee-result handshakes of the parking fee unit.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready; the producer holds valid and payload stable until then.
interface parking_fee_unit_if;
    import parking_pkg::*;

    logic             exit_valid;
    logic             exit_ready;
    logic [1:0]       car_id;
    logic [7:0]       duration;
    logic [3:0]       rate;
    logic             fee_valid;
    logic             fee_ready;
    logic [FEE_W-1:0] fee;
    logic [1:0]       fee_car_id;

    modport master (
        output exit_valid, car_id, duration, rate, fee_ready,
        input  exit_ready, fee_valid, fee, fee_car_id
    );

    modport slave (
        input  exit_valid, car_id, duration, rate, fee_ready,
        output exit_ready, fee_valid, fee, fee_car_id
    );

endinterface

// File: rtl/fee_mult.sv
// Serial shift-add multiplier: one multiplier bit per cycle over four steps.
// Operands are held stable by the caller for the whole run. Steps 0..2 are
// accumulated into acc_q; step 3 is presented combinationally on product
// while done is high, so the caller registers the final result on that edge.
module fee_mult
    import parking_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       mcand,
    input  logic [3:0]       mplier,
    output logic             done,
    output logic [FEE_W-1:0] product
);

    logic [FEE_W-1:0] acc_q, acc_d;
    logic [1:0]       step_q, step_d;
    logic             busy_q, busy_d;
    logic [FEE_W-1:0] partial;
    logic [FEE_W-1:0] acc_sum;

    // Next-state for the accumulator and step counter.
    always_comb begin
        partial = mplier[step_q] ? ({{(FEE_W-8){1'b0}}, mcand} << step_q) : '0;
        acc_sum = acc_q + partial;
        done    = busy_q && (step_q == 2'd3);
        product = acc_sum;
        acc_d   = acc_q;
        step_d  = step_q;
        busy_d  = busy_q;
        if (start) begin
            acc_d  = '0;
            step_d = 2'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d  = acc_sum;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
                busy_d = 1'b0;
            end
        end
    end

    // Multiplier state registers; reset abandons any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            step_q <= 2'd0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/parking_fee_unit.sv
// Parking exit fee unit: accepts an exit, computes base + rate*billable
// serially, presents the fee until the consumer takes it, then books revenue.
module parking_fee_unit
    import parking_pkg::*;
#(
    parameter int FREE_UNITS = FREE_UNITS_DEF,
    parameter int BASE_FEE   = BASE_FEE_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    parking_fee_unit_if.slave bus,
    output logic [REV_W-1:0] revenue,
    output logic [7:0]       txn_count,
    output logic [1:0]       err_flags,
    output fee_state_e       state_dbg
);

    localparam logic [7:0]       FREE_U8  = 8'(FREE_UNITS);
    localparam logic [FEE_W-1:0] BASE_EXT = FEE_W'(BASE_FEE);

    fee_state_e       state_q, state_d;
    logic [1:0]       car_q, car_d;
    logic [7:0]       dur_q, dur_d;
    logic [3:0]       rate_q, rate_d;
    logic             fee_valid_q, fee_valid_d;
    logic [FEE_W-1:0] fee_q, fee_d;
    logic [1:0]       fee_car_q, fee_car_d;
    logic [REV_W-1:0] revenue_q, revenue_d;
    logic [7:0]       txn_q, txn_d;
    logic [1:0]       err_q, err_d;

    logic             accept;
    logic             mult_done;
    logic [FEE_W-1:0] mult_product;
    logic [REV_W:0]   rev_sum;

    // Operands come from the captured registers, so they stay stable through CALC.
    fee_mult u_fee_mult (
        .clk     (clk),
        .rst_n   (reset_n),
        .start   (accept),
        .mcand   (billable_units(dur_q, FREE_U8)),
        .mplier  (rate_q),
        .done    (mult_done),
        .product (mult_product)
    );

    // FSM next-state, operand capture, fee presentation and bookkeeping.
    always_comb begin
        state_d     = state_q;
        car_d       = car_q;
        dur_d       = dur_q;
        rate_d      = rate_q;
        fee_valid_d = fee_valid_q;
        fee_d       = fee_q;
        fee_car_d   = fee_car_q;
        revenue_d   = revenue_q;
        txn_d       = txn_q;
        err_d       = err_q;
        accept      = 1'b0;
        rev_sum     = {1'b0, revenue_q} + {{(REV_W-FEE_W+1){1'b0}}, fee_q};
        case (state_q)
            ST_IDLE: begin
                if (bus.exit_valid) begin
                    if ((bus.car_id != 2'd0) && (bus.duration != 8'd0)) begin
                        accept  = 1'b1;
                        state_d = ST_CALC;
                        car_d   = bus.car_id;
                        dur_d   = bus.duration;
                        rate_d  = bus.rate;
                    end else begin
                        err_d[1] = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (mult_done) begin
                    state_d     = ST_PRESENT;
                    fee_valid_d = 1'b1;
                    fee_d       = BASE_EXT + mult_product;
                    fee_car_d   = car_q;
                end
            end
            ST_PRESENT: begin
                if (bus.fee_ready) begin
                    state_d     = ST_IDLE;
                    fee_valid_d = 1'b0;
                    revenue_d   = rev_sum[REV_W] ? {REV_W{1'b1}} : rev_sum[REV_W-1:0];
                    txn_d       = txn_q + 8'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                fee_valid_d = 1'b0;
            end
        endcase
        // Exits arriving while busy are dropped; the in-flight result is untouched.
        if (bus.exit_valid && (state_q != ST_IDLE)) begin
            err_d[0] = 1'b1;
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            car_q       <= '0;
            dur_q       <= '0;
            rate_q      <= '0;
            fee_valid_q <= 1'b0;
            fee_q       <= '0;
            fee_car_q   <= '0;
            revenue_q   <= '0;
            txn_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            car_q       <= car_d;
            dur_q       <= dur_d;
            rate_q      <= rate_d;
            fee_valid_q <= fee_valid_d;
            fee_q       <= fee_d;
            fee_car_q   <= fee_car_d;
            revenue_q   <= revenue_d;
            txn_q       <= txn_d;
            err_q       <= err_d;
        end
    end

    assign bus.exit_ready = (state_q == ST_IDLE);
    assign bus.fee_valid  = fee_valid_q;
    assign bus.fee        = fee_q;
    assign bus.fee_car_id = fee_car_q;
    assign revenue        = revenue_q;
    assign txn_count      = txn_q;
    assign err_flags      = err_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_parking_fee_unit.sv
// Directed bench for parking_fee_unit with an expected-fee scoreboard.
module tb_parking_fee_unit;
    import parking_pkg::*;

    logic clk;
    logic reset_n;

    logic [15:0] revenue;
    logic [7:0]  txn_count;
    logic [1:0]  err_flags;
    fee_state_e  state_dbg;

    parking_fee_unit_if bus ();

    parking_fee_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .revenue   (revenue),
        .txn_count (txn_count),
        .err_flags (err_flags),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [13:0] exp_q[$];       // {car_id, fee}
    int          n_checks;
    int          n_fail;
    int          rev_model;
    logic [7:0]  txn_model;
    logic [11:0] held_fee;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_fee(input logic [7:0] d, input logic [3:0] r);
        int bill;
        bill = (int'(d) > 4) ? int'(d) - 4 : 0;
        return 12'(5 + int'(r) * bill);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        rev_model = 0;
        txn_model = 8'd0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Issue an exit in IDLE, check the 4-edge latency, then compare the presented fee.
    task automatic accept_and_wait(input logic [1:0] c, input logic [7:0] d,
                                   input logic [3:0] r, output logic [11:0] fee_exp);
        logic [13:0] e;
        int          guard;
        @(negedge clk);
        check("exit_ready_idle", 32'(bus.exit_ready), 32'd1);
        exp_q.push_back({c, model_fee(d, r)});
        bus.exit_valid = 1'b1;
        bus.car_id     = c;
        bus.duration   = d;
        bus.rate       = r;
        @(posedge clk);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) bus.exit_valid = 1'b0;
            check("latency_fee_valid", 32'(bus.fee_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        guard = 0;
        while (bus.fee_valid !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        fee_exp = 12'd0;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL sb_underflow observed=0 expected=1");
        end else begin
            e       = exp_q.pop_front();
            fee_exp = e[11:0];
            check("fee", 32'(bus.fee), 32'(e[11:0]));
            check("fee_car_id", 32'(bus.fee_car_id), 32'(e[13:12]));
        end
    endtask

    // One fee transfer starting from a negedge in PRESENT.
    task automatic transfer(input logic [11:0] fee_exp);
        bus.fee_ready = 1'b1;
        check("exit_ready_present", 32'(bus.exit_ready), 32'd0);
        @(posedge clk);
        rev_model = (rev_model + int'(fee_exp) > 65535) ? 65535 : rev_model + int'(fee_exp);
        txn_model = txn_model + 8'd1;
        @(negedge clk);
        bus.fee_ready = 1'b0;
        check("fee_valid_after_xfer", 32'(bus.fee_valid), 32'd0);
        check("exit_ready_after_xfer", 32'(bus.exit_ready), 32'd1);
        check("revenue", 32'(revenue), 32'(rev_model));
        check("txn_count", 32'(txn_count), 32'(txn_model));
    endtask

    task automatic run_txn(input logic [1:0] c, input logic [7:0] d, input logic [3:0] r);
        logic [11:0] f;
        accept_and_wait(c, d, r, f);
        transfer(f);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [11:0] f;
        n_checks       = 0;
        n_fail         = 0;
        rev_model      = 0;
        txn_model      = 8'd0;
        reset_n        = 1'b0;
        bus.exit_valid = 1'b0;
        bus.car_id     = 2'd0;
        bus.duration   = 8'd0;
        bus.rate       = 4'd0;
        bus.fee_ready  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_fee_valid", 32'(bus.fee_valid), 32'd0);
        check("rst_fee", 32'(bus.fee), 32'd0);
        check("rst_fee_car_id", 32'(bus.fee_car_id), 32'd0);
        check("rst_revenue", 32'(revenue), 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
        check("rst_err", 32'(err_flags), 32'd0);
        check("rst_exit_ready", 32'(bus.exit_ready), 32'd1);
        reset_n = 1'b1;

        // Basic transaction: fee 23
        run_txn(2'd2, 8'd10, 4'd3);
        check("basic_revenue", 32'(revenue), 32'd23);

        // Free-unit boundary
        run_txn(2'd1, 8'd3, 4'd15);
        run_txn(2'd3, 8'd4, 4'd15);
        run_txn(2'd1, 8'd5, 4'd15);

        // Maximum fee and revenue saturation from a clean start
        apply_reset();
        for (int i = 0; i < 18; i++) run_txn(2'd2, 8'd255, 4'd15);
        check("sat_revenue", 32'(revenue), 32'd65535);
        check("sat_txn", 32'(txn_count), 32'd18);
        check("sat_err_clean", 32'(err_flags), 32'd0);

        // Back-pressure with dropped exits
        accept_and_wait(2'd3, 8'd20, 4'd2, f);
        held_fee = f;
        for (int i = 0; i < 10; i++) begin
            bus.exit_valid = (i % 2 == 0);
            bus.car_id     = 2'($urandom_range(1, 3));
            bus.duration   = 8'($urandom_range(1, 255));
            bus.rate       = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("hold_fee", 32'(bus.fee), 32'(held_fee));
            check("hold_fee_valid", 32'(bus.fee_valid), 32'd1);
            check("hold_car", 32'(bus.fee_car_id), 32'd3);
        end
        bus.exit_valid = 1'b0;
        check("drop_err", 32'(err_flags), 32'd1);
        transfer(held_fee);
        bus.fee_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.fee_ready = 1'b0;
        check("single_xfer_txn", 32'(txn_count), 32'(txn_model));
        check("single_xfer_rev", 32'(revenue), 32'(rev_model));
        check("single_xfer_valid", 32'(bus.fee_valid), 32'd0);

        // Invalid exits in IDLE
        bus.exit_valid = 1'b1;
        bus.car_id     = 2'd1;
        bus.duration   = 8'd0;
        @(negedge clk);
        check("inv_dur_ready", 32'(bus.exit_ready), 32'd1);
        check("inv_dur_state", 32'(state_dbg), 32'(ST_IDLE));
        bus.car_id   = 2'd0;
        bus.duration = 8'd9;
        @(negedge clk);
        check("inv_car_ready", 32'(bus.exit_ready), 32'd1);
        check("inv_car_state", 32'(state_dbg), 32'(ST_IDLE));
        bus.exit_valid = 1'b0;
        check("inv_err", 32'(err_flags), 32'd3);
        repeat (5) @(negedge clk);
        check("inv_no_fee", 32'(bus.fee_valid), 32'd0);

        // Reset in the second CALC cycle
        bus.exit_valid = 1'b1;
        bus.car_id     = 2'd2;
        bus.duration   = 8'd100;
        bus.rate       = 4'd9;
        @(posedge clk);
        @(negedge clk);
        bus.exit_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_state_calc", 32'(state_dbg), 32'(ST_CALC));
        reset_n = 1'b0;
        #1;
        check("mid_rst_fee_valid", 32'(bus.fee_valid), 32'd0);
        check("mid_rst_fee", 32'(bus.fee), 32'd0);
        check("mid_rst_car", 32'(bus.fee_car_id), 32'd0);
        check("mid_rst_revenue", 32'(revenue), 32'd0);
        check("mid_rst_txn", 32'(txn_count), 32'd0);
        check("mid_rst_err", 32'(err_flags), 32'd0);
        check("mid_rst_exit_ready", 32'(bus.exit_ready), 32'd1);
        rev_model = 0;
        txn_model = 8'd0;
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(2'd1, 8'd12, 4'd7);
        check("post_rst_revenue", 32'(revenue), 32'd61);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
